// File: rtl/id_stage_if.sv
// Decode-stage buses: fetch handshake, gpr read ports, writeback, EX bundle.
// slave is the decode stage's view, master is the surrounding pipeline's.
interface id_stage_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          i_if_valid;
  logic          o_if_ready;
  logic [31:0]   i_if_pc;
  logic [31:0]   i_if_inst;
  logic          o_rs1_re;
  logic [AW-1:0] o_rs1_addr;
  logic [DW-1:0] i_rs1_r_data;
  logic          o_rs2_re;
  logic [AW-1:0] o_rs2_addr;
  logic [DW-1:0] i_rs2_r_data;
  logic          i_wb_we;
  logic [AW-1:0] i_wb_addr;
  logic          o_ex_valid;
  logic          i_ex_ready;
  logic [31:0]   o_ex_pc;
  logic [6:0]    o_ex_opcode;
  logic [2:0]    o_ex_funct3;
  logic          o_ex_funct7b5;
  logic [DW-1:0] o_ex_rs1_data;
  logic [DW-1:0] o_ex_rs2_data;
  logic [31:0]   o_ex_imm;
  logic [AW-1:0] o_ex_rd_addr;
  logic          o_ex_rd_we;
  logic          o_ex_illegal;

  modport slave (
    input  i_if_valid, i_if_pc, i_if_inst,
    input  i_rs1_r_data, i_rs2_r_data,
    input  i_wb_we, i_wb_addr, i_ex_ready,
    output o_if_ready, o_rs1_re, o_rs1_addr,
    output o_rs2_re, o_rs2_addr, o_ex_valid,
    output o_ex_pc, o_ex_opcode, o_ex_funct3,
    output o_ex_funct7b5, o_ex_rs1_data,
    output o_ex_rs2_data, o_ex_imm,
    output o_ex_rd_addr, o_ex_rd_we, o_ex_illegal
  );

  modport master (
    output i_if_valid, i_if_pc, i_if_inst,
    output i_rs1_r_data, i_rs2_r_data,
    output i_wb_we, i_wb_addr, i_ex_ready,
    input  o_if_ready, o_rs1_re, o_rs1_addr,
    input  o_rs2_re, o_rs2_addr, o_ex_valid,
    input  o_ex_pc, o_ex_opcode, o_ex_funct3,
    input  o_ex_funct7b5, o_ex_rs1_data,
    input  o_ex_rs2_data, o_ex_imm,
    input  o_ex_rd_addr, o_ex_rd_we, o_ex_illegal
  );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: decode, hazard-checked gpr read, registered EX bundle.
// A busy-bit scoreboard set on EX handoff and cleared by writeback.
module id_stage #(
  parameter int REG_ADDR_BUS_WIDTH = 5,
  parameter int REG_DATA_BUS_WIDTH = 32,
  parameter int NUMBER_OF_GPR      = 32
) (
  input logic       i_clk,
  input logic       i_rst,
  id_stage_if.slave bus
);
  localparam int AW = REG_ADDR_BUS_WIDTH;
  localparam int DW = REG_DATA_BUS_WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_MEM   = 7'b0001111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  logic [1:0]               state_q, state_d;
  logic [31:0]              pc_q, pc_d;
  logic [31:0]              inst_q, inst_d;
  logic [NUMBER_OF_GPR-1:0] busy_q, busy_d;
  logic [31:0]              ex_pc_q, ex_pc_d;
  logic [6:0]               ex_op_q, ex_op_d;
  logic [2:0]               ex_f3_q, ex_f3_d;
  logic                     ex_f7_q, ex_f7_d;
  logic [DW-1:0]            ex_d1_q, ex_d1_d;
  logic [DW-1:0]            ex_d2_q, ex_d2_d;
  logic [31:0]              ex_imm_q, ex_imm_d;
  logic [AW-1:0]            ex_rd_q, ex_rd_d;
  logic                     ex_we_q, ex_we_d;
  logic                     ex_ill_q, ex_ill_d;

  logic [6:0]    opcode;
  logic [AW-1:0] rs1, rs2, rd;
  logic [31:0]   imm;
  logic          use1, use2, use_rd, illegal;
  logic          rd_we, rd1, rd2, haz, hs;

  assign opcode = inst_q[6:0];
  assign rs1    = inst_q[19:15];
  assign rs2    = inst_q[24:20];
  assign rd     = inst_q[11:7];

  always_comb begin
    use1    = 1'b0;
    use2    = 1'b0;
    use_rd  = 1'b0;
    illegal = 1'b0;
    imm     = '0;
    unique case (1'b1)
      opcode == OP_LUI,
      opcode == OP_AUIPC: begin
        use_rd = 1'b1;
        imm    = {inst_q[31:12], 12'h000};
      end
      opcode == OP_JAL: begin
        use_rd = 1'b1;
        imm    = {{12{inst_q[31]}}, inst_q[19:12],
                  inst_q[20], inst_q[30:21], 1'b0};
      end
      opcode == OP_JALR,
      opcode == OP_LOAD,
      opcode == OP_IMM: begin
        use1   = 1'b1;
        use_rd = 1'b1;
        imm    = {{20{inst_q[31]}}, inst_q[31:20]};
      end
      opcode == OP_BR: begin
        use1 = 1'b1;
        use2 = 1'b1;
        imm  = {{20{inst_q[31]}}, inst_q[7],
                inst_q[30:25], inst_q[11:8], 1'b0};
      end
      opcode == OP_ST: begin
        use1 = 1'b1;
        use2 = 1'b1;
        imm  = {{20{inst_q[31]}}, inst_q[31:25],
                inst_q[11:7]};
      end
      opcode == OP_OP: begin
        use1   = 1'b1;
        use2   = 1'b1;
        use_rd = 1'b1;
      end
      opcode == OP_MEM,
      opcode == OP_SYS: begin
        imm = {{20{inst_q[31]}}, inst_q[31:20]};
      end
      default: illegal = 1'b1;
    endcase
  end

  // illegal ops use no registers, so they never see a hazard
  assign rd_we = use_rd && (rd != '0);
  assign rd1   = use1 && (rs1 != '0);
  assign rd2   = use2 && (rs2 != '0);
  assign haz   = (rd1 && busy_q[rs1]) ||
                 (rd2 && busy_q[rs2]) ||
                 (rd_we && busy_q[rd]);
  assign hs    = (state_q == S_OUT) && bus.i_ex_ready;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    busy_d   = busy_q;
    ex_pc_d  = ex_pc_q;
    ex_op_d  = ex_op_q;
    ex_f3_d  = ex_f3_q;
    ex_f7_d  = ex_f7_q;
    ex_d1_d  = ex_d1_q;
    ex_d2_d  = ex_d2_q;
    ex_imm_d = ex_imm_q;
    ex_rd_d  = ex_rd_q;
    ex_we_d  = ex_we_q;
    ex_ill_d = ex_ill_q;
    if (bus.i_wb_we && (bus.i_wb_addr != '0))
      busy_d[bus.i_wb_addr] = 1'b0;
    if (hs && ex_we_q)
      busy_d[ex_rd_q] = 1'b1;
    busy_d[0] = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_if_valid) begin
          pc_d    = bus.i_if_pc;
          inst_d  = bus.i_if_inst;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (illegal || !haz)
          state_d = S_READ;
      end
      S_READ: begin
        ex_pc_d  = pc_q;
        ex_op_d  = opcode;
        ex_f3_d  = inst_q[14:12];
        ex_f7_d  = inst_q[30];
        ex_d1_d  = rd1 ? bus.i_rs1_r_data : '0;
        ex_d2_d  = rd2 ? bus.i_rs2_r_data : '0;
        ex_imm_d = imm;
        ex_rd_d  = rd;
        ex_we_d  = rd_we;
        ex_ill_d = illegal;
        state_d  = S_OUT;
      end
      S_OUT: begin
        if (bus.i_ex_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      inst_q   <= '0;
      busy_q   <= '0;
      ex_pc_q  <= '0;
      ex_op_q  <= '0;
      ex_f3_q  <= '0;
      ex_f7_q  <= 1'b0;
      ex_d1_q  <= '0;
      ex_d2_q  <= '0;
      ex_imm_q <= '0;
      ex_rd_q  <= '0;
      ex_we_q  <= 1'b0;
      ex_ill_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      busy_q   <= busy_d;
      ex_pc_q  <= ex_pc_d;
      ex_op_q  <= ex_op_d;
      ex_f3_q  <= ex_f3_d;
      ex_f7_q  <= ex_f7_d;
      ex_d1_q  <= ex_d1_d;
      ex_d2_q  <= ex_d2_d;
      ex_imm_q <= ex_imm_d;
      ex_rd_q  <= ex_rd_d;
      ex_we_q  <= ex_we_d;
      ex_ill_q <= ex_ill_d;
    end
  end

  assign bus.o_if_ready    = (state_q == S_IDLE) && !i_rst;
  assign bus.o_rs1_re      = (state_q == S_CHECK) && !haz && rd1;
  assign bus.o_rs2_re      = (state_q == S_CHECK) && !haz && rd2;
  assign bus.o_rs1_addr    = rs1;
  assign bus.o_rs2_addr    = rs2;
  assign bus.o_ex_valid    = (state_q == S_OUT);
  assign bus.o_ex_pc       = ex_pc_q;
  assign bus.o_ex_opcode   = ex_op_q;
  assign bus.o_ex_funct3   = ex_f3_q;
  assign bus.o_ex_funct7b5 = ex_f7_q;
  assign bus.o_ex_rs1_data = ex_d1_q;
  assign bus.o_ex_rs2_data = ex_d2_q;
  assign bus.o_ex_imm      = ex_imm_q;
  assign bus.o_ex_rd_addr  = ex_rd_q;
  assign bus.o_ex_rd_we    = ex_we_q;
  assign bus.o_ex_illegal  = ex_ill_q;
endmodule
